// File: rtl/clz_pkg.sv
// Shared sizing helpers for the pipelined leading-zero/one counter.
package clz_pkg;

  function automatic int clz_cw(input int width);
    return $clog2(width + 1);
  endfunction

  function automatic int clz_pad(input int width);
    return 1 << $clog2(width);
  endfunction

  // Stage s owns tree levels up to ceil((s+1)*levels/stages)-1.
  function automatic int clz_stage_of(input int level, input int levels, input int stages);
    int r;
    r = stages - 1;
    for (int s = stages - 1; s >= 0; s--) begin
      if (level <= ((s + 1) * levels + stages - 1) / stages - 1) r = s;
    end
    return r;
  endfunction

endpackage

// File: rtl/clz_pipe_level.sv
// One level of the leading-bit tree: merges N node pairs, optionally registered.
// IW == 0 selects the 2-bit encoder form, whose input positions are ignored.
module clz_pipe_level #(
  parameter int N = 1,
  parameter int IW = 0,
  parameter int DW = 1,
  parameter bit REG = 1'b0,
  localparam int IWP = (IW == 0) ? 1 : IW,
  localparam int OW = IW + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              v_in,
  input  logic [DW-1:0]     d_in,
  input  logic [2*N-1:0]    nv_in,
  input  logic [2*N*IWP-1:0] np_in,
  output logic              v_out,
  output logic [DW-1:0]     d_out,
  output logic [N-1:0]      nv_out,
  output logic [N*OW-1:0]   np_out
);

  logic [N-1:0]    nv_c;
  logic [N*OW-1:0] np_c;

  // Node 2j+1 is the more significant half of pair j.
  for (genvar j = 0; j < N; j++) begin : g_node
    logic vl, vr;
    assign vl = nv_in[2*j+1];
    assign vr = nv_in[2*j];
    assign nv_c[j] = vl | vr;
    if (IW == 0) begin : g_enc
      assign np_c[j] = ~vl;
    end else begin : g_merge
      assign np_c[j*OW +: OW] = vl ? {1'b0, np_in[(2*j+1)*IW +: IW]}
                                   : {1'b1, np_in[2*j*IW +: IW]};
    end
  end

  if (IW == 0) begin : g_enc_sink
    logic unused_np;
    assign unused_np = ^np_in;
  end

  if (REG) begin : g_reg
    always_ff @(posedge clk) begin
      if (rst) begin
        v_out  <= 1'b0;
        d_out  <= '0;
        nv_out <= '0;
        np_out <= '0;
      end else if (en) begin
        v_out  <= v_in;
        d_out  <= d_in;
        nv_out <= nv_c;
        np_out <= np_c;
      end
    end
  end else begin : g_comb
    logic unused_ctl;
    assign unused_ctl = clk ^ rst ^ en;
    assign v_out  = v_in;
    assign d_out  = d_in;
    assign nv_out = nv_c;
    assign np_out = np_c;
  end

endmodule

// File: rtl/clz_pipe.sv
// Pipelined leading-zero/one counter. Define CLZ_PIPE_NORM_EN to add a
// registered normalising shift stage and the out_norm port.
module clz_pipe
  import clz_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int PIPE_STAGES = 2,
  localparam int CW = clz_cw(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_ones,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CW-1:0]    out_count,
  output logic             out_zero
`ifdef CLZ_PIPE_NORM_EN
  ,
  output logic [WIDTH-1:0] out_norm
`endif
);

  localparam int P = clz_pad(WIDTH);
  localparam int L = $clog2(P);
`ifdef CLZ_PIPE_NORM_EN
  localparam int DW = WIDTH;
`else
  localparam int DW = 1;
`endif

  // Handshake: a word moves when valid && ready on that side. Every stage
  // shifts together on advance; a held output freezes the whole pipe, and
  // in_ready reaches out_ready only through advance.
  logic advance;
  assign advance  = out_ready || !out_valid;
  assign in_ready = advance && !rst;

  logic [WIDTH-1:0] scan_w;
  logic [P-1:0]     padded;
  logic [DW-1:0]    word_in;
  assign scan_w = in_ones ? ~in_data : in_data;

  // Ones below the LSB make an all-clear word terminate exactly at WIDTH.
  if (P > WIDTH) begin : g_pad
    assign padded = {scan_w, {(P-WIDTH){1'b1}}};
  end else begin : g_nopad
    assign padded = scan_w;
  end

`ifdef CLZ_PIPE_NORM_EN
  assign word_in = in_data;
`else
  assign word_in = 1'b0;
`endif

  for (genvar lv = 0; lv < L; lv++) begin : g_lvl
    localparam int N   = P >> (lv + 1);
    localparam int IWP = (lv == 0) ? 1 : lv;
    localparam bit REG = (lv == L - 1) ||
                         (clz_stage_of(lv, L, PIPE_STAGES) != clz_stage_of(lv + 1, L, PIPE_STAGES));
    logic                v_i, v_o;
    logic [DW-1:0]       d_i, d_o;
    logic [2*N-1:0]      nv_i;
    logic [2*N*IWP-1:0]  np_i;
    logic [N-1:0]        nv_o;
    logic [N*(lv+1)-1:0] np_o;

    if (lv == 0) begin : g_src
      assign v_i  = in_valid;
      assign d_i  = word_in;
      assign nv_i = padded;
      assign np_i = '0;
    end else begin : g_chain
      assign v_i  = g_lvl[lv-1].v_o;
      assign d_i  = g_lvl[lv-1].d_o;
      assign nv_i = g_lvl[lv-1].nv_o;
      assign np_i = g_lvl[lv-1].np_o;
    end

    clz_pipe_level #(.N(N), .IW(lv), .DW(DW), .REG(REG)) u_level (
      .clk   (clk),
      .rst   (rst),
      .en    (advance),
      .v_in  (v_i),
      .d_in  (d_i),
      .nv_in (nv_i),
      .np_in (np_i),
      .v_out (v_o),
      .d_out (d_o),
      .nv_out(nv_o),
      .np_out(np_o)
    );
  end

  logic          root_v;
  logic          root_nv;
  logic [L-1:0]  root_pos;
  logic [DW-1:0] root_word;
  logic [CW-1:0] count_c;
  logic          zero_c;

  assign root_v    = g_lvl[L-1].v_o;
  assign root_nv   = g_lvl[L-1].nv_o[0];
  assign root_pos  = g_lvl[L-1].np_o;
  assign root_word = g_lvl[L-1].d_o;
  assign count_c   = root_nv ? CW'(root_pos) : CW'(WIDTH);
  assign zero_c    = (count_c == CW'(WIDTH));

`ifdef CLZ_PIPE_NORM_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_count <= '0;
      out_zero  <= 1'b0;
      out_norm  <= '0;
    end else if (advance) begin
      out_valid <= root_v;
      out_count <= root_v ? count_c : '0;
      out_zero  <= root_v && zero_c;
      out_norm  <= (root_v && !zero_c) ? (root_word << count_c) : '0;
    end
  end
`else
  logic unused_word;
  assign unused_word = ^root_word;
  assign out_valid   = root_v;
  assign out_count   = root_v ? count_c : '0;
  assign out_zero    = root_v && zero_c;
`endif

endmodule

// File: tb/tb_clz_pipe.sv
// Directed bench for clz_pipe: a 32-bit/2-stage and a 24-bit/3-stage instance.
module tb_clz_pipe;

`ifdef CLZ_PIPE_NORM_EN
  localparam int NX = 1;
`else
  localparam int NX = 0;
`endif
  localparam int LAT_A = 2 + NX;
  localparam int LAT_B = 3 + NX;

  logic clk, rst;
  int   n_checks = 0;
  int   n_pass = 0;

  logic        a_in_valid, a_in_ready, a_in_ones, a_out_valid, a_out_ready, a_out_zero;
  logic [31:0] a_in_data;
  logic [5:0]  a_out_count;
  logic        b_in_valid, b_in_ready, b_in_ones, b_out_valid, b_out_ready, b_out_zero;
  logic [23:0] b_in_data;
  logic [4:0]  b_out_count;
`ifdef CLZ_PIPE_NORM_EN
  logic [31:0] a_out_norm;
  logic [23:0] b_out_norm;
`endif

  clz_pipe #(.WIDTH(32), .PIPE_STAGES(2)) u_dut_a (
    .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .in_ones(a_in_ones), .out_valid(a_out_valid),
    .out_ready(a_out_ready), .out_count(a_out_count), .out_zero(a_out_zero)
`ifdef CLZ_PIPE_NORM_EN
    , .out_norm(a_out_norm)
`endif
  );

  clz_pipe #(.WIDTH(24), .PIPE_STAGES(3)) u_dut_b (
    .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
    .in_data(b_in_data), .in_ones(b_in_ones), .out_valid(b_out_valid),
    .out_ready(b_out_ready), .out_count(b_out_count), .out_zero(b_out_zero)
`ifdef CLZ_PIPE_NORM_EN
    , .out_norm(b_out_norm)
`endif
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks: start and finish on a falling edge.
  task automatic drive_a(input logic [31:0] data, input logic ones);
    a_in_valid = 1'b1; a_in_data = data; a_in_ones = ones;
    @(negedge clk);
    a_in_valid = 1'b0;
  endtask

  task automatic drive_b(input logic [23:0] data, input logic ones);
    b_in_valid = 1'b1; b_in_data = data; b_in_ones = ones;
    @(negedge clk);
    b_in_valid = 1'b0;
  endtask

  task automatic wait_a(output int cyc);
    cyc = 1;
    while (!a_out_valid && cyc < 30) begin @(negedge clk); cyc++; end
  endtask

  task automatic wait_b(output int cyc);
    cyc = 1;
    while (!b_out_valid && cyc < 30) begin @(negedge clk); cyc++; end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    a_in_valid = 0; a_in_data = '0; a_in_ones = 0; a_out_ready = 1;
    b_in_valid = 0; b_in_data = '0; b_in_ones = 0; b_out_ready = 1;
    repeat (3) @(negedge clk);
    #1;
    n_checks++; if (a_out_valid !== 1'b0) $display("FAIL rst_a_valid: got %b want 0", a_out_valid); else n_pass++;
    n_checks++; if (a_out_count !== 6'd0) $display("FAIL rst_a_count: got %0d want 0", a_out_count); else n_pass++;
    n_checks++; if (a_out_zero !== 1'b0) $display("FAIL rst_a_zero: got %b want 0", a_out_zero); else n_pass++;
    n_checks++; if (a_in_ready !== 1'b0) $display("FAIL rst_a_in_ready: got %b want 0", a_in_ready); else n_pass++;
    n_checks++; if (b_out_valid !== 1'b0) $display("FAIL rst_b_valid: got %b want 0", b_out_valid); else n_pass++;
`ifdef CLZ_PIPE_NORM_EN
    n_checks++; if (a_out_norm !== 32'd0) $display("FAIL rst_a_norm: got %h want 0", a_out_norm); else n_pass++;
`endif
    rst = 1'b0;
    #1;
    n_checks++; if (a_in_ready !== 1'b1) $display("FAIL post_rst_a_in_ready: got %b want 1", a_in_ready); else n_pass++;
    n_checks++; if (b_in_ready !== 1'b1) $display("FAIL post_rst_b_in_ready: got %b want 1", b_in_ready); else n_pass++;
    @(negedge clk);
  endtask

  task automatic test_count_32();
    logic [31:0] v_data [6] = '{32'h0001_0000, 32'h0, 32'hFFF1_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0001};
    logic        v_ones [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [5:0]  v_cnt  [6] = '{6'd15, 6'd32, 6'd12, 6'd32, 6'd0, 6'd31};
    logic        v_zero [6] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [31:0] v_norm [6] = '{32'h8000_0000, 32'h0, 32'h1000_0000, 32'h0, 32'h7FFF_FFFF, 32'h8000_0000};
    int cyc;
    for (int i = 0; i < 6; i++) begin
      drive_a(v_data[i], v_ones[i]);
      wait_a(cyc);
      #1;
      n_checks++; if (cyc !== LAT_A) $display("FAIL a_latency[%0d]: got %0d want %0d", i, cyc, LAT_A); else n_pass++;
      n_checks++; if (a_out_count !== v_cnt[i]) $display("FAIL a_count[%0d]: got %0d want %0d", i, a_out_count, v_cnt[i]); else n_pass++;
      n_checks++; if (a_out_zero !== v_zero[i]) $display("FAIL a_zero[%0d]: got %b want %b", i, a_out_zero, v_zero[i]); else n_pass++;
`ifdef CLZ_PIPE_NORM_EN
      n_checks++; if (a_out_norm !== v_norm[i]) $display("FAIL a_norm[%0d]: got %h want %h", i, a_out_norm, v_norm[i]); else n_pass++;
`else
      if (v_norm[i] === 32'hx) $display("norm table entry %0d unset", i);
`endif
      @(negedge clk);
      #1;
      n_checks++; if (a_out_valid !== 1'b0) $display("FAIL a_single_shot[%0d]: got %b want 0", i, a_out_valid); else n_pass++;
      @(negedge clk);
    end
  endtask

  task automatic test_count_24();
    logic [23:0] v_data [4] = '{24'h000001, 24'h000000, 24'h800000, 24'hF0F000};
    logic        v_ones [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [4:0]  v_cnt  [4] = '{5'd23, 5'd24, 5'd0, 5'd4};
    logic        v_zero [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    logic [23:0] v_norm [4] = '{24'h800000, 24'h000000, 24'h800000, 24'h0F0000};
    int cyc;
    for (int i = 0; i < 4; i++) begin
      drive_b(v_data[i], v_ones[i]);
      wait_b(cyc);
      #1;
      n_checks++; if (cyc !== LAT_B) $display("FAIL b_latency[%0d]: got %0d want %0d", i, cyc, LAT_B); else n_pass++;
      n_checks++; if (b_out_count !== v_cnt[i]) $display("FAIL b_count[%0d]: got %0d want %0d", i, b_out_count, v_cnt[i]); else n_pass++;
      n_checks++; if (b_out_zero !== v_zero[i]) $display("FAIL b_zero[%0d]: got %b want %b", i, b_out_zero, v_zero[i]); else n_pass++;
`ifdef CLZ_PIPE_NORM_EN
      n_checks++; if (b_out_norm !== v_norm[i]) $display("FAIL b_norm[%0d]: got %h want %h", i, b_out_norm, v_norm[i]); else n_pass++;
`else
      if (v_norm[i] === 24'hx) $display("norm table entry %0d unset", i);
`endif
      @(negedge clk);
    end
  endtask

  task automatic test_back_pressure();
    logic [31:0] words [4] = '{32'h8000_0000, 32'h4000_0000, 32'h0000_0001, 32'hFFFF_FFFF};
    logic [5:0]  exp_q [$];
    logic [5:0]  e;
    int sent = 0, got = 0, stall = 0;
    bit stalled_once = 0;
    exp_q.push_back(6'd0); exp_q.push_back(6'd1); exp_q.push_back(6'd31); exp_q.push_back(6'd0);
    a_in_ones = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (a_out_valid && !stalled_once) begin stalled_once = 1; stall = 3; end
      a_out_ready = (stall == 0);
      a_in_valid  = (sent < 4);
      if (sent < 4) a_in_data = words[sent];
      #1;
      if (stall > 0) begin
        n_checks++; if (a_in_ready !== 1'b0) $display("FAIL bp_in_ready_stall: got %b want 0", a_in_ready); else n_pass++;
        n_checks++; if (a_out_valid !== 1'b1 || a_out_count !== 6'd0)
          $display("FAIL bp_hold: got valid=%b count=%0d want valid=1 count=0", a_out_valid, a_out_count); else n_pass++;
        stall--;
      end else if (sent < 4) begin
        n_checks++; if (a_in_ready !== 1'b1) $display("FAIL bp_in_ready_run: got %b want 1", a_in_ready); else n_pass++;
      end
      if (a_out_valid && a_out_ready) begin
        n_checks++;
        if (exp_q.size() == 0) $display("FAIL bp_extra: got count %0d want no result", a_out_count);
        else begin
          e = exp_q.pop_front();
          if (a_out_count !== e) $display("FAIL bp_order: got %0d want %0d", a_out_count, e); else n_pass++;
        end
        got++;
      end
      if (a_in_valid && a_in_ready) sent++;
      @(negedge clk);
    end
    a_in_valid = 1'b0; a_out_ready = 1'b1;
    n_checks++; if (got !== 4 || exp_q.size() !== 0)
      $display("FAIL bp_delivered: got %0d results want 4 (%0d missing)", got, exp_q.size()); else n_pass++;
  endtask

  task automatic test_reset_in_flight();
    int spur = 0;
    int cyc;
    a_out_ready = 1'b1; a_in_ones = 1'b0;
    a_in_valid = 1'b1; a_in_data = 32'h0000_0001;
    @(negedge clk);
    a_in_data = 32'h0000_0002;
    @(negedge clk);
    a_in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    #1;
    n_checks++; if (a_out_valid !== 1'b0) $display("FAIL flush_valid: got %b want 0", a_out_valid); else n_pass++;
    n_checks++; if (a_in_ready !== 1'b0) $display("FAIL flush_in_ready: got %b want 0", a_in_ready); else n_pass++;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #1;
      if (a_out_valid) spur++;
    end
    n_checks++; if (spur !== 0) $display("FAIL flush_spurious: got %0d results want 0", spur); else n_pass++;
    @(negedge clk);
    drive_a(32'h0000_0100, 1'b0);
    wait_a(cyc);
    #1;
    n_checks++; if (cyc !== LAT_A) $display("FAIL post_flush_latency: got %0d want %0d", cyc, LAT_A); else n_pass++;
    n_checks++; if (a_out_count !== 6'd23) $display("FAIL post_flush_count: got %0d want 23", a_out_count); else n_pass++;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_count_32();
    test_count_24();
    test_back_pressure();
    test_reset_in_flight();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
